tick_event_arbiter: RTL and testbench

Turns the divided clock outputs of the multi-rate frequency divider into single-cycle events and serialises them onto one shared consumer port (display/LED update logic). Each rising edge of a divided clock becomes a pending request. Requests are granted one at a time through a valid/ready handshake. Events that arrive while the same channel is still pending are dropped and counted. The block sits directly after the divider, in the same `clk` domain.

---
 rtl/tick_arb_pkg.sv | 13 +
 rtl/tick_edge_det.sv | 27 ++
 rtl/tick_event_arbiter.sv | 116 +++++++++++
 tb/tb_tick_event_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_arb_pkg.sv
// Shared constants for the tick event arbiter: FSM encoding, channel indices, defaults.
// Optional build macro: TICK_ARB_RR_EN (round-robin arbitration).
package tick_arb_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam int CH_1KHZ  = 0;
  localparam int CH_500HZ = 1;
  localparam int CH_1HZ   = 2;

  localparam int N_CH_DEF   = 3;
  localparam int DROP_W_DEF = 8;
endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the divided clock levels; suppresses edges until one clock after reset release.
module tick_edge_det
  import tick_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [N_CH-1:0] tick_in,
  output logic [N_CH-1:0] tick_edge
);
  logic [N_CH-1:0] tick_d;
  logic            armed;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tick_d <= '0;
      armed  <= 1'b0;
    end else begin
      tick_d <= tick_in;
      armed  <= 1'b1;
    end
  end

  // A level already high at release is not an edge: tick_d catches up while armed is still 0.
  assign tick_edge = tick_in & ~tick_d & {N_CH{armed}};
endmodule

// File: rtl/tick_event_arbiter.sv
// Serialises divided-clock rising edges onto one valid/ready event port with per-channel drop counters.
// Optional build macro: TICK_ARB_RR_EN selects round-robin instead of fixed lowest-index priority.
module tick_event_arbiter
  import tick_arb_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [N_CH-1:0]          tick_in,
  output logic                     evt_valid,
  output logic [1:0]               evt_id,
  input  logic                     evt_ready,
  output logic [N_CH-1:0]          pending,
  output logic [N_CH*DROP_W-1:0]   drop_cnt,
  input  logic                     drop_clr
);
  logic [0:0]                    state;
  logic [N_CH-1:0]               tick_edge;
  logic [N_CH-1:0]               acc;
  logic [N_CH-1:0]               drop;
  logic                          accept;
  logic [N_CH-1:0][DROP_W-1:0]   cnt;

  tick_edge_det #(.N_CH(N_CH)) u_edge (
    .clk       (clk),
    .clr_n     (clr_n),
    .tick_in   (tick_in),
    .tick_edge (tick_edge)
  );

`ifdef TICK_ARB_RR_EN
  logic [1:0] last;

  function automatic logic [1:0] pick(input logic [N_CH-1:0] req, input logic [1:0] lst);
    logic [1:0] w;
    int         idx;
    w = '0;
    // Walk backwards so the channel nearest last+1 is the final assignment.
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(lst) + k) % N_CH;
      if (req[idx]) w = 2'(idx);
    end
    return w;
  endfunction
`else
  function automatic logic [1:0] pick(input logic [N_CH-1:0] req);
    logic [1:0] w;
    w = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (req[i]) w = 2'(i);
    return w;
  endfunction
`endif

  assign evt_valid = (state == ST_OFFER);
  assign accept    = evt_valid & evt_ready;
  assign drop_cnt  = cnt;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_CH; i++)
      acc[i] = accept && (evt_id == 2'(i));
  end

  // An edge on a still-pending channel is lost unless that channel is being accepted this cycle.
  assign drop = tick_edge & pending & ~acc;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      evt_id  <= '0;
      pending <= '0;
`ifdef TICK_ARB_RR_EN
      last    <= 2'(N_CH - 1);
`endif
    end else begin
      pending <= (pending & ~acc) | tick_edge;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
`ifdef TICK_ARB_RR_EN
            evt_id <= pick(pending, last);
`else
            evt_id <= pick(pending);
`endif
            state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            state <= ST_IDLE;
`ifdef TICK_ARB_RR_EN
            last  <= evt_id;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (drop_clr)
          cnt[i] <= DROP_W'(drop[i]);
        else if (drop[i] && (cnt[i] != {DROP_W{1'b1}}))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tick_event_arbiter.sv
// Self-checking bench: cycle table for latency/arbitration, scripted corner cases, event scoreboard.
module tb_tick_event_arbiter;
  import tick_arb_pkg::*;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [2:0]  tick_in;
  logic        evt_valid;
  logic [1:0]  evt_id;
  logic        evt_ready;
  logic [2:0]  pending;
  logic [23:0] drop_cnt;
  logic        drop_clr;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  tick_event_arbiter dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .tick_in   (tick_in),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected id.
  always @(negedge clk) begin
    if (clr_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_event", 32'(evt_id), -1);
      else chk("event_id", 32'(evt_id), 32'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic [2:0] tick;
    logic       rdy;
    logic       v;
    logic [1:0] id;
    logic [2:0] p;
    logic [5:0] pids;
    int         npush;
  } vec_t;

  vec_t tbl[14];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'b001, 1'b1, 1'b0, 2'd0, 3'b000, 6'd0, 0};
    tbl[1]  = '{3'b011, 1'b1, 1'b0, 2'd0, 3'b000, 6'd1, 1};
    tbl[2]  = '{3'b011, 1'b1, 1'b0, 2'd0, 3'b010, 6'd0, 0};
    tbl[3]  = '{3'b011, 1'b1, 1'b1, 2'd1, 3'b010, 6'd0, 0};
    tbl[4]  = '{3'b011, 1'b1, 1'b0, 2'd0, 3'b000, 6'd0, 0};
    tbl[5]  = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 6'd0, 0};
`ifdef TICK_ARB_RR_EN
    // last = 1 after the channel-1 grant, so the search starts at channel 2.
    tbl[6]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 6'b01_00_10, 3};
    tbl[7]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b111, 6'd0, 0};
    tbl[8]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b111, 6'd0, 0};
    tbl[9]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b011, 6'd0, 0};
    tbl[10] = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b011, 6'd0, 0};
    tbl[11] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b010, 6'd0, 0};
    tbl[12] = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 6'd0, 0};
`else
    tbl[6]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 6'b10_01_00, 3};
    tbl[7]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b111, 6'd0, 0};
    tbl[8]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b111, 6'd0, 0};
    tbl[9]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b110, 6'd0, 0};
    tbl[10] = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b110, 6'd0, 0};
    tbl[11] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b100, 6'd0, 0};
    tbl[12] = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 6'd0, 0};
`endif
    tbl[13] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 6'd0, 0};

    // Reset with channel 0 already high.
    clr_n = 1'b0; tick_in = 3'b001; evt_ready = 1'b0; drop_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    cyc();
    clr_n = 1'b1;

    // Latency, no event for the level high at release, fixed/RR ordering.
    for (int r = 0; r < 14; r++) begin
      cyc();
      tick_in = tbl[r].tick; evt_ready = tbl[r].rdy; drop_clr = 1'b0;
      for (int j = 0; j < tbl[r].npush; j++) exp_q.push_back(tbl[r].pids[2*j +: 2]);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), 32'(evt_valid), 32'(tbl[r].v));
      chk($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].p));
      if (tbl[r].v) chk($sformatf("tbl%0d_id", r), 32'(evt_id), 32'(tbl[r].id));
    end

    // Stalled consumer: three edges on channel 0, two of them dropped.
    cyc(); tick_in = 3'b000; evt_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc();
      tick_in[0] = ((j % 6) >= 3);
      if (j == 3) exp_q.push_back(2'(CH_1KHZ));
      @(negedge clk);
      if (j == 5) chk("stall_valid_t2", 32'(evt_valid), 1);
      if (evt_valid) chk("stall_id_stable", 32'(evt_id), 0);
    end
    chk("stall_drop0", 32'(drop_cnt[7:0]), 2);
    cyc(); evt_ready = 1'b1;
    cyc(); evt_ready = 1'b0;
    @(negedge clk);
    chk("stall_after_valid", 32'(evt_valid), 0);
    chk("stall_after_pending", 32'(pending), 0);
    repeat (3) cyc();
    @(negedge clk);
    chk("stall_single_event", 32'(evt_valid), 0);

    // Edge on the offered channel in its acceptance cycle.
    cyc(); tick_in = 3'b001; exp_q.push_back(2'd0);
    cyc(); tick_in = 3'b000;
    cyc();
    @(negedge clk);
    chk("same_offer_valid", 32'(evt_valid), 1);
    cyc(); tick_in = 3'b001; evt_ready = 1'b1; exp_q.push_back(2'd0);
    cyc();
    @(negedge clk);
    chk("same_k1_valid", 32'(evt_valid), 0);
    chk("same_k1_pending", 32'(pending), 1);
    cyc();
    @(negedge clk);
    chk("same_k2_valid", 32'(evt_valid), 1);
    chk("same_k2_id", 32'(evt_id), 0);
    cyc();
    @(negedge clk);
    chk("same_k3_pending", 32'(pending), 0);
    chk("same_drop0", 32'(drop_cnt[7:0]), 2);

    // Saturation on channel 2, then clear coinciding with a drop.
    cyc(); tick_in = 3'b000; evt_ready = 1'b0;
    for (int j = 0; j < 602; j++) begin
      cyc();
      tick_in[2] = ((j % 2) == 0);
      if (j == 0) exp_q.push_back(2'(CH_1HZ));
      if (j == 100) begin
        @(negedge clk);
        chk("sat_mid_drop2", 32'(drop_cnt[23:16]), 49);
      end
    end
    @(negedge clk);
    chk("sat_drop2", 32'(drop_cnt[23:16]), 255);
    chk("sat_offer_id", 32'(evt_id), 2);
    cyc(); tick_in = 3'b100; drop_clr = 1'b1;
    cyc(); drop_clr = 1'b0; tick_in = 3'b000;
    @(negedge clk);
    chk("clr_drop2", 32'(drop_cnt[23:16]), 1);
    chk("clr_drop0", 32'(drop_cnt[7:0]), 0);
    cyc(); evt_ready = 1'b1;
    cyc(); evt_ready = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset during OFFER.
    cyc(); tick_in = 3'b010; exp_q.push_back(2'(CH_500HZ));
    cyc(); tick_in = 3'b000;
    cyc(); tick_in = 3'b010;
    cyc();
    @(negedge clk);
    chk("arst_pre_valid", 32'(evt_valid), 1);
    chk("arst_pre_drop1", 32'(drop_cnt[15:8]), 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_drop_cnt", 32'(drop_cnt), 0);
    exp_q.delete();
    repeat (2) cyc();
    clr_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc();
      @(negedge clk);
      chk("arst_quiet_valid", 32'(evt_valid), 0);
      chk("arst_quiet_pending", 32'(pending), 0);
    end
    cyc(); tick_in = 3'b000;
    cyc(); tick_in = 3'b010; evt_ready = 1'b1; exp_q.push_back(2'd1);
    cyc();
    cyc();
    @(negedge clk);
    chk("arst_new_valid", 32'(evt_valid), 1);
    chk("arst_new_id", 32'(evt_id), 1);
    repeat (2) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
